conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Sequences one 2D convolution over the matrices held by the input-memory block. When `inputs_loaded` is high it walks every valid output window and issues X/W read addresses. It drives the MAC datapath's enable, clear and last strobes aligned to the 1-cycle memory read latency, and presents each finished output through a valid/ready handshake. It pulses `compute_finished` after the final output is accepted, which releases the memory bank to the loader.

## Interface
- `R`, 9, rows of X
- `C`, 8, columns of X
- `MAXK`, 4, largest supported K
- `K_BITS` (local), `$clog2(MAXK+1)`
- `X_ADDR_BITS` (local), `$clog2(R*C)`
- `W_ADDR_BITS` (local), `$clog2(MAXK*MAXK)`

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `inputs_loaded`  in  1  memories hold a complete X, W, K, B
- `K`  in  K_BITS  weight size from the input-memory block
- `X_read_addr`  out  X_ADDR_BITS  row-major X address
- `W_read_addr`  out  W_ADDR_BITS  row-major W address (i*K+j)
- `mac_en`  out  1  X_data/W_data are valid this cycle; accumulate the product
- `mac_clear`  out  1  with `mac_en`: load the product and discard the old sum (first term)
- `mac_last`  out  1  with `mac_en`: last term of the current window
- `out_valid`  out  1  accumulator+B result is valid
- `out_last`  out  1  with `out_valid`: final output of the matrix
- `out_ready`  in  1  downstream accepts the result
- `compute_finished`  out  1  one-cycle pulse, whole matrix done
- `cfg_err`  out  1  one-cycle pulse with `compute_finished` when K is invalid

## Operation
- States: IDLE, RUN, DRAIN, OUT, DONE.
- IDLE: when `inputs_loaded`=1, latch K into `k_lat` and clear counters r, c, i, j to 0.
  - If 2<=K<=MAXK, go to RUN.
  - Otherwise go to DONE with `cfg_err`.
- RUN: one address pair per cycle.
  - `X_read_addr`=(r+i)*C+(c+j); `W_read_addr`=i*k_lat+j.
  - j increments; at j=k_lat-1, j wraps to 0 and i increments.
  - When i=j=k_lat-1, go to DRAIN.
- DRAIN: issues no new address; the last product is accumulated this cycle. Go to OUT.
- OUT: `out_valid`=1, held until `out_ready`.
  - On handshake, advance c; at c=C-k_lat, c wraps to 0 and r increments.
  - If this was the last window (r=R-k_lat, c=C-k_lat), go to DONE; else go to RUN with i=j=0.
- `out_last`=1 in OUT only for the last window.
- DONE: `compute_finished`=1 for one cycle, then IDLE.
- In IDLE the block samples `inputs_loaded` no earlier than the cycle after DONE, so a second bank that is already loaded starts with no extra idle cycle.
- Output count is (R-k_lat+1)*(C-k_lat+1); each output uses k_lat² terms.
- Address arithmetic is unsigned. The maximum X address is R*C-1 and must never exceed it.
- K is ignored outside IDLE; changes while busy have no effect.

## Timing
- Reset (synchronous) forces IDLE and clears every output to 0: addresses, `mac_*`, `out_*`, `compute_finished`, `cfg_err`. Counters are also cleared.
  - Reset mid-RUN or mid-OUT abandons the matrix without a `compute_finished` pulse.
- `mac_en` is `(state==RUN)` registered once, so it is high in the cycle after each address (read latency 1).
  - `mac_clear` marks the term i=j=0.
  - `mac_last` marks the term i=j=k_lat-1 and always falls in DRAIN.
- Per window with `out_ready`=1: k_lat² RUN cycles + 1 DRAIN + 1 OUT.
- `out_valid` rises the cycle after DRAIN. Once high it stays high and its data is stable until `out_ready`.
- With `out_ready` low in OUT, addresses hold their last value and `mac_en` stays 0.
- `compute_finished` rises in the cycle after the final OUT handshake; `cfg_err` rises in the cycle after IDLE sees an invalid K.
- `inputs_loaded` falling mid-matrix is a protocol violation. Behaviour is undefined; no checking is required.

## Structure
- Package `conv_pkg`: the state enum typedef `conv_state_t`, plus width helper constants shared with the input-memory block (K_BITS, X_ADDR_BITS, W_ADDR_BITS as functions of R, C, MAXK).
- Sub-module `window_addr_gen` holds the r/c/i/j counters and incremental address computation, with `step`/`next_window`/`clear` controls and `win_last`/`term_last` flags. `conv_sequencer` keeps the FSM and strobe pipeline.

## Test plan
- R=9, C=8, K=3, `out_ready`=1: the first window issues X 0,1,2,8,9,10,16,17,18 and W 0..8. There are 42 outputs, each with exactly 9 `mac_en` pulses. `compute_finished` fires once, 462 cycles after start.
- Same setup: window 2 starts at X=1, window 7 (r=1,c=0) starts at X=8, and the last window ends at X=71 with `out_last`=1.
- K=4: 30 outputs of 16 terms each, W addresses 0..15 per window, `mac_clear` only on term 0 and `mac_last` only on term 15.
- `out_ready` held low for 5 cycles at output 3: `out_valid` stays high, addresses are frozen, `mac_en`=0, and the sequence resumes unchanged.
- K=1 and K=5 (with MAXK=4): `cfg_err` and `compute_finished` pulse together with no address activity. `inputs_loaded` still high after DONE (second bank) restarts RUN with no extra idle cycle.
- Reset asserted mid-RUN: the next cycle all outputs are 0 and the block is in IDLE. A new start then reproduces the first-window address sequence exactly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution sequencer and input-memory block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: conv_state_t FSM encoding; k_bits/x_addr_bits/w_addr_bits width functions of R, C, MAXK.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } conv_state_t;

  // K must be able to hold MAXK itself, not just MAXK-1.
  function automatic int k_bits(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int x_addr_bits(input int r, input int c);
    return $clog2(r * c);
  endfunction

  function automatic int w_addr_bits(input int maxk);
    return $clog2(maxk * maxk);
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window/term counters with incremental X and W address generation for one convolution.
// Latency: addresses are registered and change on the edge where step/next_window/clear is sampled.
// Backpressure: counters and addresses hold whenever no control is asserted.
// Ports: clk, reset; k (window size); clear/step/next_window controls;
//        x_addr/w_addr current read addresses; term_first/term_last/win_last position flags.
module window_addr_gen
  import conv_pkg::*;
#(
  parameter int R    = 9,
  parameter int C    = 8,
  parameter int MAXK = 4,
  localparam int K_BITS      = k_bits(MAXK),
  localparam int X_ADDR_BITS = x_addr_bits(R, C),
  localparam int W_ADDR_BITS = w_addr_bits(MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [K_BITS-1:0]      k,
  input  logic                   clear,
  input  logic                   step,
  input  logic                   next_window,
  output logic [X_ADDR_BITS-1:0] x_addr,
  output logic [W_ADDR_BITS-1:0] w_addr,
  output logic                   term_first,
  output logic                   term_last,
  output logic                   win_last
);

  localparam int R_BITS = $clog2(R + 1);
  localparam int C_BITS = $clog2(C + 1);

  logic [R_BITS-1:0]      r;
  logic [C_BITS-1:0]      c;
  logic [K_BITS-1:0]      i;
  logic [K_BITS-1:0]      j;
  // X address of term (0,0) of the current window, i.e. r*C + c.
  logic [X_ADDR_BITS-1:0] x_base;
  logic                   j_last;
  logic                   c_last;

  always_comb begin
    j_last     = (int'(j) == int'(k) - 1);
    c_last     = (int'(c) == C - int'(k));
    term_first = (i == '0) && (j == '0);
    term_last  = (int'(i) == int'(k) - 1) && j_last;
    win_last   = (int'(r) == R - int'(k)) && c_last;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r      <= '0;
      c      <= '0;
      i      <= '0;
      j      <= '0;
      x_base <= '0;
      x_addr <= '0;
      w_addr <= '0;
    end else if (step) begin
      // W is row-major i*K+j, so within a window it simply counts up.
      w_addr <= w_addr + 1'b1;
      if (j_last) begin
        j      <= '0;
        i      <= i + 1'b1;
        // Jump from (r+i, c+K-1) to (r+i+1, c).
        x_addr <= X_ADDR_BITS'(int'(x_addr) + C + 1 - int'(k));
      end else begin
        j      <= j + 1'b1;
        x_addr <= x_addr + 1'b1;
      end
    end else if (next_window) begin
      i      <= '0;
      j      <= '0;
      w_addr <= '0;
      if (c_last) begin
        // Base moves from r*C + (C-K) to (r+1)*C.
        c      <= '0;
        r      <= r + 1'b1;
        x_base <= X_ADDR_BITS'(int'(x_base) + int'(k));
        x_addr <= X_ADDR_BITS'(int'(x_base) + int'(k));
      end else begin
        c      <= c + 1'b1;
        x_base <= x_base + 1'b1;
        x_addr <= x_base + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Sequences one 2D convolution: walks every output window, issues X/W reads, drives MAC strobes.
// Latency: MAC strobes trail their address by 1 cycle; per window K*K RUN + 1 DRAIN + 1 OUT cycle.
// Backpressure: out_valid holds in OUT until out_ready; addresses freeze and mac_en stays low meanwhile.
// Ports: clk, reset (sync, active-high); inputs_loaded/K start a matrix; X_read_addr/W_read_addr reads;
//        mac_en/mac_clear/mac_last MAC strobes; out_valid/out_last/out_ready result handshake;
//        compute_finished/cfg_err end-of-matrix pulses.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int R    = 9,
  parameter int C    = 8,
  parameter int MAXK = 4,
  localparam int K_BITS      = k_bits(MAXK),
  localparam int X_ADDR_BITS = x_addr_bits(R, C),
  localparam int W_ADDR_BITS = w_addr_bits(MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  output logic                   mac_en,
  output logic                   mac_clear,
  output logic                   mac_last,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   compute_finished,
  output logic                   cfg_err
);

  conv_state_t       state;
  logic [K_BITS-1:0] k_lat;
  logic              err_flag;
  logic              k_ok;
  logic              start;
  logic              step;
  logic              next_window;
  logic              term_first;
  logic              term_last;
  logic              win_last;

  assign k_ok        = (int'(K) >= 2) && (int'(K) <= MAXK);
  // Counters are only cleared for a valid start so a rejected K leaves the address bus untouched.
  assign start       = (state == ST_IDLE) && inputs_loaded && k_ok;
  // The final term keeps its address through DRAIN/OUT; next_window re-bases afterwards.
  assign step        = (state == ST_RUN) && !term_last;
  assign next_window = (state == ST_OUT) && out_ready && !win_last;

  window_addr_gen #(
    .R    (R),
    .C    (C),
    .MAXK (MAXK)
  ) u_addr (
    .clk         (clk),
    .reset       (reset),
    .k           (k_lat),
    .clear       (start),
    .step        (step),
    .next_window (next_window),
    .x_addr      (X_read_addr),
    .w_addr      (W_read_addr),
    .term_first  (term_first),
    .term_last   (term_last),
    .win_last    (win_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      k_lat     <= '0;
      err_flag  <= 1'b0;
      mac_en    <= 1'b0;
      mac_clear <= 1'b0;
      mac_last  <= 1'b0;
    end else begin
      // Memory read latency is one cycle, so strobes follow the address cycle.
      mac_en    <= (state == ST_RUN);
      mac_clear <= (state == ST_RUN) && term_first;
      mac_last  <= (state == ST_RUN) && term_last;
      case (state)
        ST_IDLE: begin
          if (inputs_loaded) begin
            k_lat    <= K;
            err_flag <= !k_ok;
            state    <= k_ok ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (term_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) state <= win_last ? ST_DONE : ST_RUN;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid        = (state == ST_OUT);
  assign out_last         = (state == ST_OUT) && win_last;
  assign compute_finished = (state == ST_DONE);
  assign cfg_err          = (state == ST_DONE) && err_flag;

endmodule

// File: tb/tb_conv_sequencer.sv
// Testbench for conv_sequencer: directed and randomized matrices against an arithmetic window model.
// Latency: n/a.
// Backpressure: out_ready is driven directed or random.
module tb_conv_sequencer;

  localparam int R    = 9;
  localparam int C    = 8;
  localparam int MAXK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inputs_loaded = 1'b0;
  logic [2:0] K = 3'd0;
  logic       out_ready = 1'b0;
  logic [6:0] X_read_addr;
  logic [3:0] W_read_addr;
  logic       mac_en, mac_clear, mac_last;
  logic       out_valid, out_last, compute_finished, cfg_err;

  int errors = 0;
  int checks = 0;

  conv_sequencer #(.R(R), .C(C), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset            (reset),
    .inputs_loaded    (inputs_loaded),
    .K                (K),
    .X_read_addr      (X_read_addr),
    .W_read_addr      (W_read_addr),
    .mac_en           (mac_en),
    .mac_clear        (mac_clear),
    .mac_last         (mac_last),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .out_ready        (out_ready),
    .compute_finished (compute_finished),
    .cfg_err          (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window n is at (n / ncols, n % ncols); term t is at (t / k, t % k).
  function automatic int exp_x(input int k, input int win, input int term);
    int ncols;
    ncols = C - k + 1;
    return (win / ncols + term / k) * C + (win % ncols) + (term % k);
  endfunction

  // mode 0: out_ready always 1; mode 1: random out_ready; mode 2: 5-cycle stall at output 3.
  task automatic run_matrix(input int k, input int mode, input bit keep);
    int nwin, win, term, stalls, cyc, stall_left;
    logic [6:0] px, fx;
    logic [3:0] pw, fw;
    bit done, in_out, prev_last;
    nwin = (R - k + 1) * (C - k + 1);
    win = 0; term = 0; stalls = 0; cyc = 0; stall_left = 0;
    done = 0; in_out = 0; prev_last = 0;
    px = X_read_addr; pw = W_read_addr; fx = px; fw = pw;
    K = 3'(k);
    inputs_loaded = 1'b1;
    out_ready = 1'b1;
    while (!done && cyc < 4000) begin
      tick();
      cyc++;
      if (mac_en) begin
        check("x_addr", px, exp_x(k, win, term));
        check("w_addr", pw, term);
        check("mac_clear", mac_clear, term == 0);
        check("mac_last", mac_last, term == k * k - 1);
        term++;
      end else begin
        check("strobes_without_en", {mac_clear, mac_last}, 0);
      end
      if (prev_last) check("valid_after_drain", out_valid, 1);
      prev_last = mac_last;
      if (out_valid) begin
        check("mac_en_in_out", mac_en, 0);
        if (!in_out) begin
          in_out = 1;
          check("terms_per_output", term, k * k);
          check("out_last", out_last, win == nwin - 1);
          fx = X_read_addr;
          fw = W_read_addr;
          if (mode == 2 && win == 3) stall_left = 5;
        end else begin
          check("x_frozen", X_read_addr, fx);
          check("w_frozen", W_read_addr, fw);
        end
        if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else if (mode == 2) out_ready = (stall_left == 0);
        else out_ready = 1'b1;
        if (stall_left > 0) stall_left--;
        if (out_ready) begin
          win++;
          term = 0;
          in_out = 0;
        end else begin
          stalls++;
        end
      end else begin
        out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (compute_finished) begin
        done = 1;
        check("finish_cycle", cyc, 1 + nwin * (k * k + 2) + stalls);
        check("outputs_seen", win, nwin);
        check("cfg_err_valid_k", cfg_err, 0);
      end
      px = X_read_addr;
      pw = W_read_addr;
    end
    check("finished_in_budget", done, 1);
    if (!keep) inputs_loaded = 1'b0;
    tick();
    check("finish_pulse_width", compute_finished, 0);
  endtask

  // Invalid K with inputs_loaded left high; K=3 is queued for the following bank.
  task automatic bad_k(input int k);
    logic [6:0] x0;
    logic [3:0] w0;
    x0 = X_read_addr;
    w0 = W_read_addr;
    K = 3'(k);
    inputs_loaded = 1'b1;
    tick();
    check("bad_k_cfg_err", cfg_err, 1);
    check("bad_k_finished", compute_finished, 1);
    check("bad_k_mac_en", mac_en, 0);
    check("bad_k_x_hold", X_read_addr, x0);
    check("bad_k_w_hold", W_read_addr, w0);
    K = 3'd3;
    tick();
    check("bad_k_pulse_width", {cfg_err, compute_finished, mac_en}, 0);
    check("bad_k_x_idle", X_read_addr, x0);
  endtask

  task automatic reset_mid(input int lo, input int hi);
    K = 3'd3;
    inputs_loaded = 1'b1;
    out_ready = 1'b1;
    repeat ($urandom_range(lo, hi)) tick();
    reset = 1'b1;
    inputs_loaded = 1'b0;
    tick();
    check("reset_mid_outputs", {X_read_addr, W_read_addr, mac_en, mac_clear, mac_last,
                                out_valid, out_last, compute_finished, cfg_err}, 0);
    reset = 1'b0;
    repeat (3) begin
      tick();
      check("post_reset_idle", {compute_finished, mac_en, out_valid, X_read_addr}, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {X_read_addr, W_read_addr, mac_en, mac_clear, mac_last,
                            out_valid, out_last, compute_finished, cfg_err}, 0);
    reset = 1'b0;
    tick();
    check("idle_quiet", {X_read_addr, W_read_addr, mac_en, out_valid, compute_finished, cfg_err}, 0);

    run_matrix(3, 0, 1'b0);
    run_matrix(4, 0, 1'b0);
    run_matrix(3, 2, 1'b0);

    bad_k(1);
    run_matrix(3, 0, 1'b0);
    bad_k(5);
    run_matrix(3, 1, 1'b0);

    run_matrix(2, 1, 1'b1);
    run_matrix(4, 1, 1'b0);

    reset_mid(2, 9);
    run_matrix(3, 0, 1'b0);
    reset_mid(20, 400);
    run_matrix(3, 0, 1'b0);

    repeat (3) run_matrix($urandom_range(2, 4), 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
